// File: rtl/router_arb_pkg.sv
// Shared constants and state type for the router injection arbiter.
package router_arb_pkg;
    localparam int NUM_SRC_DEF = 4;
    localparam int PCK_SZ_DEF  = 40;

    typedef enum logic {IDLE, OFFER} arb_state_t;
endpackage

// File: rtl/router_inject_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
    import router_arb_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int IDXW    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic               vld,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDXW-1:0]    idx
);
    int w_j;

    // Scan from the farthest offset down so the nearest requester is the last write.
    always_comb begin
        vld = 1'b0;
        gnt = '0;
        idx = '0;
        w_j = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_j = (int'(ptr) + k) % NUM_SRC;
            if (req[w_j]) begin
                vld      = 1'b1;
                gnt      = '0;
                gnt[w_j] = 1'b1;
                idx      = IDXW'(w_j);
            end
        end
    end
endmodule

// File: rtl/router_inject_arb.sv
// Round-robin injection arbiter: NUM_SRC show-ahead sources feed one router port.
// Optional per-source consumed-packet counters enabled by ROUTER_INJECT_ARB_CNT_EN.
module router_inject_arb
    import router_arb_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int PCK_SZ  = PCK_SZ_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*PCK_SZ-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_pndng,
    output logic [NUM_SRC-1:0]        src_pop,
    output logic [PCK_SZ-1:0]         data_out_i_in,
    output logic                      pndng_i_in,
`ifdef ROUTER_INJECT_ARB_CNT_EN
    output logic [NUM_SRC*16-1:0]     grant_cnt,
`endif
    input  logic                      pop
);
    localparam int IDXW = $clog2(NUM_SRC);

    arb_state_t          r_state, w_state_nxt;
    logic [IDXW-1:0]     r_ptr;
    logic [PCK_SZ-1:0]   r_hold;
    logic [IDXW-1:0]     r_src;
    logic                w_vld;
    logic [NUM_SRC-1:0]  w_gnt;
    logic [IDXW-1:0]     w_idx;
    logic                w_slot_free;
    logic                w_sel;

    rr_pick #(.NUM_SRC(NUM_SRC), .IDXW(IDXW)) u_pick (
        .req (src_pndng),
        .ptr (r_ptr),
        .vld (w_vld),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    // The holding slot can take a new packet when empty or being drained this cycle.
    assign w_slot_free = !rst && ((r_state == IDLE) || pop);
    assign w_sel       = w_slot_free && w_vld;

    assign src_pop       = w_sel ? w_gnt : '0;
    assign pndng_i_in    = (r_state == OFFER);
    assign data_out_i_in = r_hold;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_vld) w_state_nxt = OFFER;
            OFFER:   if (pop)   w_state_nxt = w_vld ? OFFER : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_src   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sel) begin
                r_hold <= src_data[w_idx*PCK_SZ +: PCK_SZ];
                r_src  <= w_idx;
                r_ptr  <= (w_idx == IDXW'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

`ifdef ROUTER_INJECT_ARB_CNT_EN
    logic [15:0] r_cnt [NUM_SRC];

    // Credit the source whose packet the router actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
        end else if ((r_state == OFFER) && pop && (r_cnt[r_src] != 16'hFFFF)) begin
            r_cnt[r_src] <= r_cnt[r_src] + 16'd1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) grant_cnt[i*16 +: 16] = r_cnt[i];
    end
`endif
endmodule

// File: tb/tb_router_inject_arb.sv
// Randomized + directed bench for router_inject_arb against a queue-based reference model.
module tb_router_inject_arb;
    localparam int NUM_SRC = 4;
    localparam int PCK_SZ  = 40;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC*PCK_SZ-1:0] src_data;
    logic [NUM_SRC-1:0]        src_pndng;
    logic [NUM_SRC-1:0]        src_pop;
    logic [PCK_SZ-1:0]         data_out_i_in;
    logic                      pndng_i_in;
    logic                      pop;
`ifdef ROUTER_INJECT_ARB_CNT_EN
    logic [NUM_SRC*16-1:0]     grant_cnt;
`endif

    router_inject_arb #(.NUM_SRC(NUM_SRC), .PCK_SZ(PCK_SZ)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_data      (src_data),
        .src_pndng     (src_pndng),
        .src_pop       (src_pop),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
`ifdef ROUTER_INJECT_ARB_CNT_EN
        .grant_cnt     (grant_cnt),
`endif
        .pop           (pop)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Source FIFOs and the model of what the arbiter should be holding.
    logic [PCK_SZ-1:0] q [NUM_SRC][$];
    logic              m_vld;
    logic [PCK_SZ-1:0] m_pkt;
    int                m_src;
    int                m_ptr;
    int                m_cnt [NUM_SRC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after negedge, check, then advance the model.
    task automatic cyc(input logic r, input logic p);
        int w;
        logic [NUM_SRC-1:0] exp_pop;
        @(negedge clk);
        rst = r;
        pop = p;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_pndng[i] = (q[i].size() != 0);
            src_data[i*PCK_SZ +: PCK_SZ] = (q[i].size() != 0) ? q[i][0] : '0;
        end
        #1;
        chk("pndng_i_in", 64'(pndng_i_in), 64'(m_vld));
        if (m_vld) chk("data_out", 64'(data_out_i_in), 64'(m_pkt));
        w = -1;
        if (!r && (!m_vld || p))
            for (int k = 0; k < NUM_SRC; k++)
                if (w < 0 && q[(m_ptr + k) % NUM_SRC].size() != 0) w = (m_ptr + k) % NUM_SRC;
        exp_pop = '0;
        if (w >= 0) exp_pop[w] = 1'b1;
        chk("src_pop", 64'(src_pop), 64'(exp_pop));
        if (r) begin
            m_vld = 1'b0;
            m_pkt = '0;
            m_ptr = 0;
            for (int i = 0; i < NUM_SRC; i++) m_cnt[i] = 0;
        end else begin
            if (m_vld && p) begin
                if (m_cnt[m_src] < 65535) m_cnt[m_src]++;
                m_vld = 1'b0;
            end
            if (w >= 0) begin
                m_pkt = q[w].pop_front();
                m_src = w;
                m_vld = 1'b1;
                m_ptr = (w + 1) % NUM_SRC;
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 64; n++) cyc(1'b0, 1'b1);
    endtask

    logic [PCK_SZ-1:0] pk;

    initial begin
        rst = 1'b1; pop = 1'b0; src_pndng = '0; src_data = '0;
        m_vld = 1'b0; m_pkt = '0; m_src = 0; m_ptr = 0;
        for (int i = 0; i < NUM_SRC; i++) m_cnt[i] = 0;

        // Reset with sources pending: no pop may leak out.
        q[1].push_back(40'h11_1111_1111);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        @(negedge clk); #1;
        chk("rst_data", 64'(data_out_i_in), 64'h0);
        chk("rst_pndng", 64'(pndng_i_in), 64'h0);
        q[1].delete();

        // Single source on index 2.
        q[2].push_back(40'hA5_0000_0002);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("single_idle", 64'(pndng_i_in), 64'h0);

        // All four pending, router always popping.
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < NUM_SRC; i++) q[i].push_back({8'hB0 + 8'(i), 32'(n)});
        drain();

        // Backpressure for 10 cycles while holding a packet.
        q[1].push_back(40'hC1_0000_0001);
        q[1].push_back(40'hC1_0000_0002);
        for (int n = 0; n < 11; n++) cyc(1'b0, 1'b0);
        drain();

        // Fairness between sources 0 and 3.
        for (int n = 0; n < 4; n++) begin
            q[0].push_back({8'hD0, 32'(n)});
            q[3].push_back({8'hD3, 32'(n)});
        end
        drain();

        // Reset while holding a packet, then 0 and 3 compete.
        q[2].push_back(40'hE2_0000_0001);
        q[2].push_back(40'hE2_0000_0002);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        q[0].push_back(40'hE0_0000_0000);
        q[3].push_back(40'hE3_0000_0003);
        drain();
        q[2].delete();

        // Random traffic and random backpressure.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                pk = {$urandom(), $urandom()} & 40'hFF_FFFF_FFFF;
                q[$urandom_range(0, NUM_SRC - 1)].push_back(pk);
            end
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end
        drain();

`ifdef ROUTER_INJECT_ARB_CNT_EN
        cyc(1'b1, 1'b0);
        for (int n = 0; n < 5; n++) q[1].push_back({8'hF1, 32'(n)});
        drain();
        @(negedge clk); #1;
        for (int i = 0; i < NUM_SRC; i++)
            chk($sformatf("grant_cnt%0d", i), 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
        chk("grant_cnt1_five", 64'(grant_cnt[16 +: 16]), 64'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/router_inject_arb.md
ROUTER_INJECT_ARB -- requirements
Module: router_inject_arb

Interface
REQ-001 Parameter NUM_SRC, default 4, number of local packet sources sharing one router external port (2..16).
REQ-002 Parameter PCK_SZ, default 40, packet width in bits.
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port src_data  input  NUM_SRC x PCK_SZ  show-ahead head packet of each source FIFO.
REQ-006 Port src_pndng  input  NUM_SRC  source i holds a valid head packet.
REQ-007 Port src_pop  output  NUM_SRC  one-cycle pop to source i; at most one bit high per cycle.
REQ-008 Port data_out_i_in  output  PCK_SZ  packet offered to router.
REQ-009 Port pndng_i_in  output  1  offered packet valid.
REQ-010 Port pop  input  1  router consumes the offered packet this cycle.

Function
REQ-011 FSM states: IDLE (no packet held), OFFER (packet held, pndng_i_in=1).
REQ-012 Selection: round-robin over src_pndng, starting search at pointer rr_ptr, wrapping NUM_SRC-1 -> 0.
REQ-013 IDLE with any src_pndng in cycle t: src_pop[winner]=1 in cycle t, hold_reg <= src_data[winner], state -> OFFER, pndng_i_in=1 from t+1.
REQ-014 IDLE with no src_pndng: src_pop all 0, stay IDLE.
REQ-015 OFFER without pop: data_out_i_in and pndng_i_in stable; src_pop all 0; no new selection.
REQ-016 OFFER with pop and any src_pndng: select next winner in same cycle, pop it, reload hold_reg, stay OFFER (back-to-back, one packet per cycle sustained).
REQ-017 OFFER with pop and no src_pndng: state -> IDLE, pndng_i_in=0 next cycle.
REQ-018 rr_ptr <= (winner+1) mod NUM_SRC on every selection; unchanged otherwise.
REQ-019 pop while pndng_i_in=0 ignored; no state or pointer change.
REQ-020 data_out_i_in in IDLE retains last value (don't-care to router); bench checks it only when pndng_i_in=1.
REQ-021 Packets pass unmodified, bit-exact, width PCK_SZ.

Reset
REQ-022 rst=1 at a clock edge: state IDLE, pndng_i_in=0, src_pop=0, rr_ptr=0, hold_reg=0, data_out_i_in=0.
REQ-023 Reset during OFFER discards held packet; no src_pop issued in reset cycle.
REQ-024 First selection after reset release starts search at source 0.

Configuration
REQ-025 Macro ROUTER_INJECT_ARB_CNT_EN defined: extra output grant_cnt (NUM_SRC x 16), per-source count of packets consumed by router (pop while OFFER), saturating at 16'hFFFF, cleared by rst.
REQ-026 Macro undefined: grant_cnt port and counters absent; all other behaviour identical.

Structure
REQ-027 Shared package router_arb_pkg: PCK_SZ default constant, NUM_SRC default constant, arb_state_t enum {IDLE, OFFER}.
REQ-028 Sub-module rr_pick: combinational round-robin picker (inputs req vector, rr_ptr; outputs valid, one-hot grant, winner index); router_inject_arb instantiates one.

Verification
REQ-029 Single source: src_pndng=4'b0100, src_data[2]=40'hA5_0000_0002, pop held 1 -> src_pop=4'b0100 at t, pndng_i_in=1 with 40'hA5_0000_0002 at t+1, IDLE at t+2 once source empties.
REQ-030 All four pending, pop always 1 -> grant order 0,1,2,3,0,... one packet per cycle, no bubbles.
REQ-031 Backpressure: pop=0 for 10 cycles during OFFER -> data_out_i_in unchanged, src_pop all 0 for all 10 cycles.
REQ-032 Fairness: src 0 and 3 continuously pending, 8 pops -> 4 grants each, alternating 0,3.
REQ-033 Reset mid-OFFER with packet held -> next cycle pndng_i_in=0, rr_ptr=0; later src_pndng=4'b1001 -> source 0 granted first.
REQ-034 With ROUTER_INJECT_ARB_CNT_EN: 5 pops from source 1 -> grant_cnt[1]=5, others 0; counter preloaded near max stays 16'hFFFF after further pops.
